// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage register-write scoreboard.
// Latency classes give the bubble count a back-to-back dependent needs.
package hazard_scoreboard_pkg;

  localparam int REGFILE_LOGSIZE = 5;
  localparam int NUM_REGS        = 2 ** REGFILE_LOGSIZE;
  localparam int CNT_W           = 4;

  localparam logic [CNT_W-1:0] LAT_ALU  = CNT_W'(0);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAT_MUL  = CNT_W'(2);
  localparam logic [CNT_W-1:0] LAT_DIV  = {CNT_W{1'b1}};

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: a saturating countdown of cycles until the pending
// result of this register reaches the forwarding network.
module sb_entry #(
  parameter int CNT_W = hazard_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dec;

  // A newer write only ever lengthens the wait, so an older long-latency
  // producer is never hidden by a short one (WAW).
  always_comb begin
    dec   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    cnt_d = dec;
    if (load_en && (load_val > dec)) begin
      cnt_d = load_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled
  // on the clock edge and, like flush, overrides a simultaneous load.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = |cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: tracks multi-cycle producers until their results
// are forwardable and stalls decode on a source that is not yet available.
module hazard_scoreboard #(
  parameter int REGFILE_LOGSIZE = hazard_scoreboard_pkg::REGFILE_LOGSIZE,
  parameter int CNT_W           = hazard_scoreboard_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  logic                          issue_regwr,
  input  logic [REGFILE_LOGSIZE-1:0]    issue_rd,
  input  logic [CNT_W-1:0]              issue_lat,
  input  logic [REGFILE_LOGSIZE-1:0]    RegR1,
  input  logic [REGFILE_LOGSIZE-1:0]    RegR2,
  input  logic                          use_r1,
  input  logic                          use_r2,
  input  logic                          flush,
  output logic                          stall,
  output logic                          haz_r1,
  output logic                          haz_r2,
  output logic [2**REGFILE_LOGSIZE-1:0] pending
);

  localparam int N = 2 ** REGFILE_LOGSIZE;

  logic [CNT_W-1:0] cnt [N];
  logic             accept;

  // A stalled instruction is not issued, so its own destination is not
  // tracked until it actually leaves decode.
  assign accept = issue_valid && !stall && issue_regwr && (issue_rd != '0);

  // x0 is hardwired zero and never produces a hazard.
  assign cnt[0]     = '0;
  assign pending[0] = 1'b0;

  for (genvar r = 1; r < N; r++) begin : g_entry
    sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .load_en  (accept && (issue_rd == REGFILE_LOGSIZE'(r))),
      .load_val (issue_lat),
      .cnt      (cnt[r]),
      .busy     (pending[r])
    );
  end

  // Read-port muxes stay purely combinational so the stall reacts in the
  // same cycle the dependent instruction sits in decode.
  assign haz_r1 = use_r1 && (RegR1 != '0) && (cnt[RegR1] != '0);
  assign haz_r2 = use_r2 && (RegR2 != '0) && (cnt[RegR2] != '0);
  assign stall  = haz_r1 | haz_r2;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic compared against a per-register countdown reference model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_regwr;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_lat;
  logic [4:0]  RegR1;
  logic [4:0]  RegR2;
  logic        use_r1;
  logic        use_r2;
  logic        flush;
  logic        stall;
  logic        haz_r1;
  logic        haz_r2;
  logic [31:0] pending;

  int          checks = 0;
  int          errors = 0;
  int          m_cnt [32];
  logic        last_stall;
  logic        last_h2;
  logic [31:0] last_pending;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_regwr (issue_regwr),
    .issue_rd    (issue_rd),
    .issue_lat   (issue_lat),
    .RegR1       (RegR1),
    .RegR2       (RegR2),
    .use_r1      (use_r1),
    .use_r2      (use_r2),
    .flush       (flush),
    .stall       (stall),
    .haz_r1      (haz_r1),
    .haz_r2      (haz_r2),
    .pending     (pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One decode cycle: drive inputs, compare outputs with the model, clock,
  // then advance the model by the scoreboard rules.
  task automatic cycle(input logic rst, input logic iv, input logic irw,
                       input int rd, input int lat, input int r1, input int r2,
                       input logic u1, input logic u2, input logic fl);
    logic        e1, e2, es, acc;
    logic [31:0] ep;
    int          d;
    rst_n       = rst;
    issue_valid = iv;
    issue_regwr = irw;
    issue_rd    = 5'(rd);
    issue_lat   = 4'(lat);
    RegR1       = 5'(r1);
    RegR2       = 5'(r2);
    use_r1      = u1;
    use_r2      = u2;
    flush       = fl;
    #1;
    e1 = u1 && (r1 != 0) && (m_cnt[r1] != 0);
    e2 = u2 && (r2 != 0) && (m_cnt[r2] != 0);
    es = e1 || e2;
    ep = '0;
    for (int i = 1; i < 32; i++) ep[i] = (m_cnt[i] != 0);
    check("haz_r1", haz_r1, e1);
    check("haz_r2", haz_r2, e2);
    check("stall", stall, es);
    check("pending", pending, ep);
    last_stall   = stall;
    last_h2      = haz_r2;
    last_pending = pending;
    acc = iv && !es && irw && (rd != 0);
    @(posedge clk);
    for (int i = 1; i < 32; i++) begin
      if (!rst || fl) begin
        m_cnt[i] = 0;
      end else begin
        d = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        if (acc && (i == rd) && (lat > d)) d = lat;
        m_cnt[i] = d;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int rd, lat, sel;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    rst_n = 1'b0; issue_valid = 1'b0; issue_regwr = 1'b0; issue_rd = '0;
    issue_lat = '0; RegR1 = '0; RegR2 = '0; use_r1 = 1'b0; use_r2 = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held while an issue is presented.
    cycle(0, 1, 1, 5, 3, 5, 0, 1, 0, 0);
    cycle(0, 1, 1, 5, 3, 5, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 5, 0, 1, 0, 0);
    check("rst_pending", last_pending, 32'h0);
    check("rst_stall", last_stall, 1'b0);

    // Load-use: one bubble.
    cycle(1, 1, 1, 7, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 8, 0, 0, 7, 0, 1, 0);
    check("lu_stall", last_stall, 1'b1);
    check("lu_haz_r2", last_h2, 1'b1);
    cycle(1, 1, 1, 8, 0, 0, 7, 0, 1, 0);
    check("lu_release", last_stall, 1'b0);

    // Multiply chain; the stalled instruction's rd=4 is not tracked yet.
    idle(2);
    cycle(1, 1, 1, 3, 2, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 4, 1, 3, 0, 1, 0, 0);
    check("mul_stall1", last_stall, 1'b1);
    cycle(1, 1, 1, 4, 1, 3, 0, 1, 0, 0);
    check("mul_stall2", last_stall, 1'b1);
    check("mul_rd4_untracked", last_pending[4], 1'b0);
    cycle(1, 1, 1, 4, 1, 3, 0, 1, 0, 0);
    check("mul_release", last_stall, 1'b0);
    idle(1);
    check("mul_rd4_tracked", last_pending[4], 1'b1);

    // WAW keeps the longer latency.
    idle(2);
    cycle(1, 1, 1, 9, 4, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 9, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 9, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 9, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 9, 0, 1, 0, 0);
    check("waw_stall_t4", last_stall, 1'b1);
    cycle(1, 0, 0, 0, 0, 9, 0, 1, 0, 0);
    check("waw_release_t5", last_stall, 1'b0);

    // use gating and x0.
    cycle(1, 1, 1, 9, 3, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 9, 0, 0, 0, 0);
    check("use_gate", last_stall, 1'b0);
    idle(4);
    cycle(1, 1, 1, 0, 5, 0, 0, 1, 1, 0);
    idle(1);
    check("x0_pending", last_pending, 32'h0);

    // Flush overrides a simultaneous issue.
    cycle(1, 1, 1, 12, 10, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 12, 2, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 12, 0, 1, 0, 0);
    check("flush_stall", last_stall, 1'b0);
    check("flush_pending", last_pending, 32'h0);

    // Random traffic over a small register window to force frequent hazards.
    for (int n = 0; n < 3000; n++) begin
      rd  = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      if (sel < 4)      lat = 0;
      else if (sel < 6) lat = 1;
      else if (sel < 8) lat = 2;
      else              lat = $urandom_range(0, 15);
      cycle(($urandom_range(0, 199) != 0), 1'($urandom), 1'($urandom), rd, lat,
            $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-write scoreboard for the integer pipeline. Tracks in-flight destination registers of multi-cycle producers (loads, multiplier, divider) from issue until their result reaches the forwarding network, and raises a decode stall when a source operand cannot yet be supplied by forwarding. It sits in decode, beside the forwarding unit. The forwarding unit handles results that are already in the bypass stages. This block handles results that are not there yet.

## Interface

Parameters:
- REGFILE_LOGSIZE, 5, register address width; 2**REGFILE_LOGSIZE entries are tracked.
- CNT_W, 4, width of the per-register countdown; maximum issue latency is 2**CNT_W-1.

Ports:
- clk  in  1  clock; one clock domain, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_regwr  in  1  instruction writes a destination register.
- issue_rd  in  REGFILE_LOGSIZE  destination register of the issuing instruction.
- issue_lat  in  CNT_W  bubble cycles a back-to-back dependent needs; 0 = fully forwardable (ALU).
- RegR1  in  REGFILE_LOGSIZE  operand_1 field of the instruction in decode.
- RegR2  in  REGFILE_LOGSIZE  operand_2 field of the instruction in decode.
- use_r1  in  1  instruction in decode reads RegR1.
- use_r2  in  1  instruction in decode reads RegR2.
- flush  in  1  pipeline drained; clear all tracking.
- stall  out  1  hold decode and fetch, insert bubble into execute.
- haz_r1  out  1  RegR1 is blocked.
- haz_r2  out  1  RegR2 is blocked.
- pending  out  2**REGFILE_LOGSIZE  bit r set when cnt[r] != 0 (debug/trace).

## Operation

- State: one counter cnt[r] of CNT_W bits per register. Register 0 has no counter and reads as 0.
- Hazard detection is combinational from registered counters:
  - haz_r1 = use_r1 && RegR1 != 0 && cnt[RegR1] != 0; haz_r2 is defined the same way.
  - stall = haz_r1 | haz_r2.
- Accepted issue = issue_valid && !stall && issue_regwr && issue_rd != 0.
- Per-cycle update of every cnt[r], in priority order:
  1. If !rst_n or flush: 0.
  2. Else if an accepted issue targets r: max(sat_dec(cnt[r]), issue_lat).
  3. Else: sat_dec(cnt[r]).
- sat_dec(x) = x-1 if x != 0, else 0. It never wraps.
- WAW: rule 2 keeps the longer outstanding latency.
- Stalled instructions are not accepted. Counters keep decrementing during a stall, so the stall self-releases.
- issue_lat = 0 on an accepted issue leaves the entry at sat_dec(cnt[r]). An ALU write never extends an older pending write.
- Intended classes: ALU 0, load 1, multiply 2, divide up to 2**CNT_W-1.

## Timing

- Reset: all counters 0, so stall, haz_r1, haz_r2 and pending are all 0 in the cycle after rst_n is sampled low.
- Issue at cycle t with lat L loads cnt = L at t+1.
- A dependent in decode at t+1 stalls for exactly L cycles (t+1 .. t+L) and proceeds at t+L+1. From that cycle the forwarding unit supplies the value.
- Outputs follow counters with zero added latency. The RegR/use inputs to stall path is combinational; no registers on it.
- Reset or flush mid-operation overrides a simultaneous issue. The entry is 0 at the next cycle.
- Issue and decrement on the same register in the same cycle: rule 2, no lost update.
- issue_rd = 0: ignored. RegRx = 0: never hazards.

## Structure

- Shared constants package holds:
  - REGFILE_LOGSIZE, reused from the existing register-file constant.
  - CNT_W.
  - Latency class constants LAT_ALU, LAT_LOAD, LAT_MUL, LAT_DIV.
- One sub-module, sb_entry: a single CNT_W counter implementing the priority update.
  - Inputs: clk, rst_n, flush, load_en, load_val.
  - Outputs: cnt, busy.
  - Instantiated 2**REGFILE_LOGSIZE-1 times by generate.
- Top level contains the issue decoder, the two read muxes and the stall OR.

## Test plan

- Reset: hold rst_n=0 with issue_valid=1, issue_rd=5, lat=3 → pending=0 and stall=0 after release; RegR1=5, use_r1=1 gives stall=0.
- Load-use: issue rd=7, lat=1 at t; at t+1 RegR2=7, use_r2=1 → stall=1 for one cycle, haz_r2=1; stall=0 at t+2.
- Multiply chain: issue rd=3, lat=2; dependent RegR1=3 at t+1 → stall at t+1 and t+2, release at t+3. The stalled instruction's own rd=4 is not tracked until accepted.
- WAW: rd=9 lat=4 at t, then rd=9 lat=1 at t+1 → cnt[9]=3 at t+2, not 1; dependent stalls through t+4.
- x0 and use gating:
  - issue rd=0 lat=5 → pending=0.
  - RegR1=9 with cnt[9]!=0 and use_r1=0 → no stall.
- Flush: rd=12 lat=10 outstanding, pulse flush together with an issue rd=12 lat=2 → cnt[12]=0 next cycle, stall=0.
